// File: rtl/encode_arith_pkg.sv
// ----------------------------------------------------------------------------
// encode_arith_pkg
// Shared arithmetic helpers for the encoder datapath stages.
//   - calc_t        : wide signed scratch type; every intermediate that must
//                     never wrap (rounding add, accumulator sum) is formed here.
//   - acc_op_e      : decoded accumulator operation for one sample.
//   - round_const() : half-LSB rounding constant for a given right shift.
//   - sat_to_width(): clamp a calc_t value to the signed range of 'width' bits.
//   - PROD_WIDTH, ROUND_CONST, OUT_MAX, OUT_MIN: values for the default
//     encoder configuration (40x27 operands, shift 8, 32-bit output).
// ----------------------------------------------------------------------------
package encode_arith_pkg;

    // Scratch width; must exceed (accumulator width + 1) of any user.
    localparam int unsigned CALC_WIDTH = 32'd256;

    localparam int unsigned DEF_DIN0_WIDTH = 32'd40;
    localparam int unsigned DEF_DIN1_WIDTH = 32'd27;
    localparam int unsigned DEF_ACC_WIDTH  = 32'd80;
    localparam int unsigned DEF_SHIFT      = 32'd8;
    localparam int unsigned DEF_DOUT_WIDTH = 32'd32;

    localparam int unsigned PROD_WIDTH = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;

    typedef logic signed [CALC_WIDTH-1:0] calc_t;

    typedef enum logic [1:0] {
        ACC_OP_BYPASS = 2'b00,
        ACC_OP_LOAD   = 2'b01,
        ACC_OP_ADD    = 2'b10
    } acc_op_e;

    localparam calc_t CALC_ONE = {{(CALC_WIDTH-1){1'b0}}, 1'b1};

    // acc_clr only has meaning together with acc_en.
    function automatic acc_op_e decode_acc_op(input logic acc_en, input logic acc_clr);
        acc_op_e op;
        if (!acc_en) begin
            op = ACC_OP_BYPASS;
        end else if (acc_clr) begin
            op = ACC_OP_LOAD;
        end else begin
            op = ACC_OP_ADD;
        end
        return op;
    endfunction

    // 2^(shift-1) for shift > 0, else 0: adding it before >>> gives round-half-up.
    function automatic calc_t round_const(input int unsigned shift);
        calc_t rc;
        if (shift > 32'd0) begin
            rc = CALC_ONE <<< (shift - 32'd1);
        end else begin
            rc = '0;
        end
        return rc;
    endfunction

    // Clamp to [-2^(width-1), 2^(width-1)-1]; result stays sign-extended.
    function automatic calc_t sat_to_width(input calc_t value, input int unsigned width);
        calc_t max_v;
        calc_t min_v;
        calc_t res;
        max_v = (CALC_ONE <<< (width - 32'd1)) - CALC_ONE;
        min_v = ~max_v;
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

    localparam calc_t             ROUND_CONST = round_const(DEF_SHIFT);
    localparam logic signed [31:0] OUT_MAX    = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] OUT_MIN    = 32'sh8000_0000;

endpackage

// File: rtl/encode_round_sat.sv
// ----------------------------------------------------------------------------
// encode_round_sat
// Combinational round-half-up arithmetic right shift followed by saturation
// from an ACC_WIDTH signed value to a dout_WIDTH signed value.
// Ports:
//   din  [ACC_WIDTH]  in   signed value to scale
//   dout [dout_WIDTH] out  rounded, shifted, saturated value
//   sat               out  1 when dout was clipped
// ----------------------------------------------------------------------------
module encode_round_sat
    import encode_arith_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned SHIFT      = DEF_SHIFT,
    parameter int unsigned dout_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  din,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         sat
);

    calc_t ext_s;
    calc_t rounded_s;
    calc_t shifted_s;
    calc_t clipped_s;
    logic  unused_hi_s;

    // Rounding add is done at CALC_WIDTH so it can never wrap.
    always_comb begin
        ext_s     = CALC_WIDTH'(din);
        rounded_s = ext_s + round_const(SHIFT);
        shifted_s = rounded_s >>> SHIFT;
        clipped_s = sat_to_width(shifted_s, dout_WIDTH);
    end

    assign dout        = clipped_s[dout_WIDTH-1:0];
    assign sat         = (clipped_s != shifted_s);
    assign unused_hi_s = ^clipped_s[CALC_WIDTH-1:dout_WIDTH];

endmodule

// File: rtl/encode_mul_acc_pipe.sv
// ----------------------------------------------------------------------------
// encode_mul_acc_pipe
// Pipelined signed multiply / multiply-accumulate with rounding right shift
// and output saturation. Latency NUM_STAGE+1 enabled cycles, 1 sample/cycle.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   ce         in   clock enable; 0 freezes every register
//   in_valid   in   din0/din1/acc_en/acc_clr qualify this cycle
//   din0       in   signed operand A [din0_WIDTH]
//   din1       in   signed operand B [din1_WIDTH]
//   acc_en     in   1 = accumulate, 0 = plain multiply
//   acc_clr    in   with acc_en: load accumulator with this product
//   out_valid  out  1-cycle pulse per result
//   dout       out  rounded/shifted/saturated result [dout_WIDTH]
//   sat        out  dout was clipped for this sample
//   acc_ovf    out  sticky accumulator saturation flag
// ----------------------------------------------------------------------------
module encode_mul_acc_pipe
    import encode_arith_pkg::*;
#(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned NUM_STAGE  = 32'd2,
    parameter int unsigned din0_WIDTH = DEF_DIN0_WIDTH,
    parameter int unsigned din1_WIDTH = DEF_DIN1_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned SHIFT      = DEF_SHIFT,
    parameter int unsigned dout_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic                         out_valid,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         sat,
    output logic                         acc_ovf
);

    localparam int unsigned PROD_W = din0_WIDTH + din1_WIDTH;

    typedef struct packed {
        logic [PROD_W-1:0] prod;
        logic              valid;
        logic              acc_en;
        logic              acc_clr;
    } stage_t;

    // ---------------------------------------------------------------- multiply
    logic signed [PROD_W-1:0] a_ext_s;
    logic signed [PROD_W-1:0] b_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    stage_t                   stage_in_s;
    stage_t                   pipe_r [NUM_STAGE];
    stage_t                   last_s;

    // Operands sign-extended to the full product width: the product is exact.
    assign a_ext_s = PROD_W'(din0);
    assign b_ext_s = PROD_W'(din1);
    assign prod_s  = a_ext_s * b_ext_s;

    // Bundle the stage-1 payload.
    always_comb begin
        stage_in_s         = '0;
        stage_in_s.prod    = prod_s;
        stage_in_s.valid   = in_valid;
        stage_in_s.acc_en  = acc_en;
        stage_in_s.acc_clr = acc_clr;
    end

    // Multiply pipeline: stage 0 captures, later stages shift; ce freezes all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 32'd0; i < NUM_STAGE; i++) begin
                pipe_r[i] <= '0;
            end
        end else if (ce) begin
            pipe_r[0] <= stage_in_s;
            for (int unsigned i = 32'd1; i < NUM_STAGE; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign last_s = pipe_r[NUM_STAGE-1];

    // ------------------------------------------------------------ accumulator
    logic signed [ACC_WIDTH-1:0]  s_ext_s;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [ACC_WIDTH-1:0]  acc_nxt_s;
    logic signed [ACC_WIDTH-1:0]  r_s;
    logic signed [ACC_WIDTH-1:0]  sum_sat_s;
    calc_t                        sum_s;
    calc_t                        sum_clip_s;
    logic                         sum_ovf_s;
    logic                         acc_ovf_r;
    logic                         acc_ovf_nxt_s;
    logic signed [dout_WIDTH-1:0] y_s;
    logic                         y_sat_s;
    logic                         out_valid_r;
    logic signed [dout_WIDTH-1:0] dout_r;
    logic                         sat_r;
    logic                         unused_sum_hi_s;
    logic [31:0]                  unused_id_s;

    assign s_ext_s = ACC_WIDTH'(signed'(last_s.prod));

    // Sum formed wide, then clamped back to the accumulator range.
    always_comb begin
        sum_s      = CALC_WIDTH'(acc_r) + CALC_WIDTH'(s_ext_s);
        sum_clip_s = sat_to_width(sum_s, ACC_WIDTH);
        sum_ovf_s  = (sum_clip_s != sum_s);
        sum_sat_s  = sum_clip_s[ACC_WIDTH-1:0];
    end

    assign unused_sum_hi_s = ^sum_clip_s[CALC_WIDTH-1:ACC_WIDTH];
    assign unused_id_s     = ID;

    // Select the value to scale and the next accumulator state for this sample.
    always_comb begin
        acc_nxt_s     = acc_r;
        acc_ovf_nxt_s = acc_ovf_r;
        r_s           = s_ext_s;
        if (last_s.valid) begin
            case (decode_acc_op(last_s.acc_en, last_s.acc_clr))
                ACC_OP_LOAD: begin
                    acc_nxt_s     = s_ext_s;
                    acc_ovf_nxt_s = 1'b0;
                    r_s           = s_ext_s;
                end
                ACC_OP_ADD: begin
                    acc_nxt_s     = sum_sat_s;
                    acc_ovf_nxt_s = acc_ovf_r | sum_ovf_s;
                    r_s           = sum_sat_s;
                end
                default: begin
                    r_s = s_ext_s;
                end
            endcase
        end else begin
            acc_nxt_s     = acc_r;
            acc_ovf_nxt_s = acc_ovf_r;
        end
    end

    encode_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT),
        .dout_WIDTH (dout_WIDTH)
    ) u_round_sat (
        .din  (r_s),
        .dout (y_s),
        .sat  (y_sat_s)
    );

    // Output stage: accumulator feedback and result registers, valid-qualified.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            sat_r       <= 1'b0;
            acc_r       <= '0;
            acc_ovf_r   <= 1'b0;
        end else if (ce) begin
            out_valid_r <= last_s.valid;
            if (last_s.valid) begin
                dout_r    <= y_s;
                sat_r     <= y_sat_s;
                acc_r     <= acc_nxt_s;
                acc_ovf_r <= acc_ovf_nxt_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign sat       = sat_r;
    assign acc_ovf   = acc_ovf_r;

endmodule

// File: tb/tb_encode_mul_acc_pipe.sv
// ----------------------------------------------------------------------------
// tb_encode_mul_acc_pipe
// Directed bench for encode_mul_acc_pipe. Instance u_dut uses the default
// configuration; instance u_dut_acc70 uses ACC_WIDTH=70 so the accumulator
// can be driven into saturation. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_encode_mul_acc_pipe;

    logic               clk;
    logic               reset_n;

    logic               ce;
    logic               in_valid;
    logic signed [39:0] din0;
    logic signed [26:0] din1;
    logic               acc_en;
    logic               acc_clr;
    logic               out_valid;
    logic signed [31:0] dout;
    logic               sat;
    logic               acc_ovf;

    logic               b_ce;
    logic               b_in_valid;
    logic signed [39:0] b_din0;
    logic signed [26:0] b_din1;
    logic               b_acc_en;
    logic               b_acc_clr;
    logic               b_out_valid;
    logic signed [31:0] b_dout;
    logic               b_sat;
    logic               b_acc_ovf;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic signed [39:0] A_MAX = 40'sh7F_FFFF_FFFF;
    localparam logic signed [39:0] A_MIN = 40'sh80_0000_0000;
    localparam logic signed [26:0] B_MAX = 27'sh3FF_FFFF;

    encode_mul_acc_pipe u_dut (
        .clk       (clk),
        .reset     (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .din0      (din0),
        .din1      (din1),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .dout      (dout),
        .sat       (sat),
        .acc_ovf   (acc_ovf)
    );

    encode_mul_acc_pipe #(.ACC_WIDTH(32'd70)) u_dut_acc70 (
        .clk       (clk),
        .reset     (reset_n),
        .ce        (b_ce),
        .in_valid  (b_in_valid),
        .din0      (b_din0),
        .din1      (b_din1),
        .acc_en    (b_acc_en),
        .acc_clr   (b_acc_clr),
        .out_valid (b_out_valid),
        .dout      (b_dout),
        .sat       (b_sat),
        .acc_ovf   (b_acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic sel, input logic v, input logic signed [39:0] a,
                         input logic signed [26:0] b, input logic en, input logic clr);
        if (sel) begin
            b_in_valid = v; b_din0 = a; b_din1 = b; b_acc_en = en; b_acc_clr = clr;
        end else begin
            in_valid = v; din0 = a; din1 = b; acc_en = en; acc_clr = clr;
        end
    endtask

    task automatic run_one(input string tag, input logic sel, input logic signed [39:0] a,
                           input logic signed [26:0] b, input logic en, input logic clr,
                           input logic signed [63:0] exp_dout, input logic exp_sat);
        drive(sel, 1'b1, a, b, en, clr);
        tick();
        drive(sel, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
        tick();
        chk({tag, "_early_valid"}, sel ? b_out_valid : out_valid, 64'sd0);
        tick();
        chk({tag, "_valid"}, sel ? b_out_valid : out_valid, 64'sd1);
        chk({tag, "_dout"}, sel ? b_dout : dout, exp_dout);
        chk({tag, "_sat"}, sel ? b_sat : sat, {63'd0, exp_sat});
        tick();
        chk({tag, "_pulse_end"}, sel ? b_out_valid : out_valid, 64'sd0);
        chk({tag, "_dout_hold"}, sel ? b_dout : dout, exp_dout);
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        b_ce    = 1'b1;
        drive(1'b0, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_valid", out_valid, 64'sd0);
        chk("rst_dout", dout, 64'sd0);
        chk("rst_sat", sat, 64'sd0);
        chk("rst_ovf", acc_ovf, 64'sd0);
        chk("rst_b_ovf", b_acc_ovf, 64'sd0);
        reset_n = 1'b1;
        tick();

        // Plain multiplies and output saturation
        run_one("mul_pos", 1'b0, 40'sd640, 27'sd1, 1'b0, 1'b0, 64'sd3, 1'b0);
        run_one("mul_neg", 1'b0, -40'sd1000, 27'sd3, 1'b0, 1'b0, -64'sd12, 1'b0);
        run_one("sat_max", 1'b0, A_MAX, B_MAX, 1'b0, 1'b0, 64'sd2147483647, 1'b1);
        run_one("sat_min", 1'b0, A_MIN, B_MAX, 1'b0, 1'b0, -64'sd2147483648, 1'b1);

        // Back-to-back accumulate chain: 256 per sample -> 1,2,3,4
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b0, 1'b1, 40'sd256, 27'sd1, 1'b1, (i == 0));
            else       drive(1'b0, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
            tick();
            if (i >= 2 && i <= 5) begin
                chk("acc_chain_valid", out_valid, 64'sd1);
                chk("acc_chain_dout", dout, 64'(i - 1));
            end
            if (i == 6) chk("acc_chain_end", out_valid, 64'sd0);
        end
        run_one("acc_reclr", 1'b0, 40'sd256, 27'sd1, 1'b1, 1'b1, 64'sd1, 1'b0);
        run_one("clr_ignored", 1'b0, 40'sd2560, 27'sd1, 1'b0, 1'b1, 64'sd10, 1'b0);
        run_one("acc_after_plain", 1'b0, 40'sd256, 27'sd1, 1'b1, 1'b0, 64'sd2, 1'b0);

        // Stall with two samples in flight; inputs during stall must be ignored
        drive(1'b0, 1'b1, 40'sd768, 27'sd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, -40'sd512, 27'sd1, 1'b0, 1'b0);
        tick();
        ce = 1'b0;
        drive(1'b0, 1'b1, 40'sd99999, 27'sd7, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", out_valid, 64'sd0);
            chk("stall_dout", dout, 64'sd2);
        end
        ce = 1'b1;
        drive(1'b0, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
        tick();
        chk("stall_a_valid", out_valid, 64'sd1);
        chk("stall_a_dout", dout, 64'sd3);
        tick();
        chk("stall_b_valid", out_valid, 64'sd1);
        chk("stall_b_dout", dout, -64'sd2);
        tick();
        chk("stall_end", out_valid, 64'sd0);

        // Asynchronous reset with samples in flight
        drive(1'b0, 1'b1, 40'sd1280, 27'sd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 40'sd2560, 27'sd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 40'sd256, 27'sd1, 1'b1, 1'b1);
        tick();
        chk("prerst_valid", out_valid, 64'sd1);
        chk("prerst_dout", dout, 64'sd5);
        drive(1'b0, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 64'sd0);
        chk("midrst_dout", dout, 64'sd0);
        chk("midrst_sat", sat, 64'sd0);
        chk("midrst_ovf", acc_ovf, 64'sd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_quiet", out_valid, 64'sd0);
        end
        run_one("acc_post_rst", 1'b0, 40'sd256, 27'sd1, 1'b1, 1'b0, 64'sd1, 1'b0);

        // Accumulator saturation on the ACC_WIDTH=70 instance
        for (int i = 0; i < 23; i++) begin
            if (i < 20) drive(1'b1, 1'b1, A_MAX, B_MAX, 1'b1, (i == 0));
            else        drive(1'b1, 1'b0, 40'sd0, 27'sd0, 1'b0, 1'b0);
            tick();
            if (i == 17) begin
                chk("ovf16_flag", b_acc_ovf, 64'sd0);
                chk("ovf16_dout", b_dout, 64'sd2147483647);
            end
            if (i == 18) begin
                chk("ovf17_valid", b_out_valid, 64'sd1);
                chk("ovf17_flag", b_acc_ovf, 64'sd1);
                chk("ovf17_dout", b_dout, 64'sd2147483647);
                chk("ovf17_sat", b_sat, 64'sd1);
            end
            if (i == 22) chk("ovf_sticky_idle", b_acc_ovf, 64'sd1);
        end
        run_one("ovf_sub", 1'b1, A_MIN, B_MAX, 1'b1, 1'b0, 64'sd2147483647, 1'b1);
        chk("ovf_sticky_sub", b_acc_ovf, 64'sd1);
        run_one("ovf_clr", 1'b1, 40'sd256, 27'sd1, 1'b1, 1'b1, 64'sd1, 1'b0);
        chk("ovf_cleared", b_acc_ovf, 64'sd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
